// File: rtl/slice_seq_be_pkg.sv
// Shared types for the slice sequencer: op/index types, FSM encoding, last-index clamp.
// Consumers: slice_seq_be (optional mask feature under SLICE_SEQ_MASK_EN) and slice_next_idx.
package pkg_tpu;

    localparam int NUM_SLICE = 16;
    localparam int IDX_W     = $clog2(NUM_SLICE);
    localparam int OP_W      = 8;

    typedef logic [OP_W-1:0]  op_t;
    typedef logic [IDX_W-1:0] index_t;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } slice_seq_state_t;

    // Limit a requested last index to the highest slice that exists.
    function automatic index_t clamp_last(input index_t raw, input int unsigned max_idx);
        clamp_last = (32'(raw) > max_idx) ? index_t'(max_idx) : raw;
    endfunction

endpackage

// File: rtl/slice_seq_be_next_idx.sv
// slice_next_idx: finds the lowest enabled slice strictly above cur and not beyond last.
// Only built when SLICE_SEQ_MASK_EN is defined.
`ifdef SLICE_SEQ_MASK_EN
module slice_next_idx
    import pkg_tpu::*;
#(
    parameter int NUM_SLICE = 16
) (
    input  logic [NUM_SLICE-1:0] mask,
    input  index_t               cur,
    input  index_t               last,
    output index_t               next_idx,
    output logic                 none_left
);

    logic [NUM_SLICE-1:0] cand_s;

    // Descending scan so the final assignment is the lowest candidate.
    always_comb begin
        cand_s   = '0;
        next_idx = '0;
        for (int j = NUM_SLICE - 1; j >= 0; j--) begin
            cand_s[j] = mask[j] & (index_t'(j) > cur) & (index_t'(j) <= last);
            next_idx  = cand_s[j] ? index_t'(j) : next_idx;
        end
        none_left = ~|cand_s;
    end

endmodule
`endif

// File: rtl/slice_seq_be.sv
// slice_seq_be: expands each accepted op into an ascending run of slice issues for the backend pipe.
// Optional macro SLICE_SEQ_MASK_EN adds I_Slice_Mask so only enabled slices are issued.
module slice_seq_be
    import pkg_tpu::*;
#(
    parameter int NUM_SLICE = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 I_Req,
    input  op_t                  I_Op,
    input  index_t               I_Last_Idx,
`ifdef SLICE_SEQ_MASK_EN
    input  logic [NUM_SLICE-1:0] I_Slice_Mask,
`endif
    output logic                 O_Stall,
    input  logic                 I_Stall,
    output logic                 O_Valid,
    output op_t                  O_Op,
    output index_t               O_Slice_Idx
);

    slice_seq_state_t state_r, state_s;
    index_t           last_r, last_s, idx_s, clamp_s, step_s, first_s;
    op_t              op_s;
    logic             valid_s, done_s, accept_s, load_s, first_none_s;

    assign clamp_s = clamp_last(I_Last_Idx, 32'(NUM_SLICE - 1));

`ifdef SLICE_SEQ_MASK_EN
    logic [NUM_SLICE-1:0] mask_r, mask_s;
    index_t               nxt_idx_s, first_nxt_s;
    logic                 nxt_none_s, first_nxt_none_s;

    slice_next_idx #(.NUM_SLICE(NUM_SLICE)) u_next (
        .mask      (mask_r),
        .cur       (O_Slice_Idx),
        .last      (last_r),
        .next_idx  (nxt_idx_s),
        .none_left (nxt_none_s)
    );

    slice_next_idx #(.NUM_SLICE(NUM_SLICE)) u_first (
        .mask      (I_Slice_Mask),
        .cur       (index_t'(0)),
        .last      (clamp_s),
        .next_idx  (first_nxt_s),
        .none_left (first_nxt_none_s)
    );

    // Slice 0 is not "above" anything, so the first enabled slice checks bit 0 separately.
    assign done_s       = nxt_none_s;
    assign step_s       = nxt_idx_s;
    assign first_s      = I_Slice_Mask[0] ? index_t'(0) : first_nxt_s;
    assign first_none_s = ~I_Slice_Mask[0] & first_nxt_none_s;
`else
    assign done_s       = (O_Slice_Idx == last_r);
    assign step_s       = O_Slice_Idx + index_t'(1);
    assign first_s      = index_t'(0);
    assign first_none_s = 1'b0;
`endif

    assign O_Stall  = (state_r == ST_ISSUE) & ~(done_s & ~I_Stall);
    assign accept_s = I_Req & ~O_Stall;

    // Next-state and next-output selection; a new op can load straight over the final slice.
    always_comb begin
        state_s = state_r;
        valid_s = O_Valid;
        op_s    = O_Op;
        idx_s   = O_Slice_Idx;
        last_s  = last_r;
        load_s  = 1'b0;
`ifdef SLICE_SEQ_MASK_EN
        mask_s  = mask_r;
`endif
        case (state_r)
            ST_IDLE: begin
                load_s = accept_s;
            end
            ST_ISSUE: begin
                if (!I_Stall && !done_s) begin
                    idx_s = step_s;
                end else if (!I_Stall) begin
                    state_s = ST_IDLE;
                    valid_s = 1'b0;
                    op_s    = '0;
                    idx_s   = '0;
                    load_s  = accept_s;
                end else begin
                    load_s  = 1'b0;
                end
            end
            default: begin
                state_s = ST_IDLE;
                valid_s = 1'b0;
                op_s    = '0;
                idx_s   = '0;
            end
        endcase

        if (load_s) begin
            last_s = clamp_s;
`ifdef SLICE_SEQ_MASK_EN
            mask_s = I_Slice_Mask;
`endif
            if (first_none_s) begin
                state_s = ST_IDLE;
                valid_s = 1'b0;
                op_s    = '0;
                idx_s   = '0;
            end else begin
                state_s = ST_ISSUE;
                valid_s = 1'b1;
                op_s    = I_Op;
                idx_s   = first_s;
            end
        end else begin
            last_s = last_r;
        end
    end

    // State and registered outputs; reset drops any op in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            O_Valid     <= 1'b0;
            O_Op        <= '0;
            O_Slice_Idx <= '0;
            last_r      <= '0;
`ifdef SLICE_SEQ_MASK_EN
            mask_r      <= '0;
`endif
        end else begin
            state_r     <= state_s;
            O_Valid     <= valid_s;
            O_Op        <= op_s;
            O_Slice_Idx <= idx_s;
            last_r      <= last_s;
`ifdef SLICE_SEQ_MASK_EN
            mask_r      <= mask_s;
`endif
        end
    end

endmodule

// File: tb/tb_slice_seq_be.sv
// Self-checking bench for slice_seq_be: queue-based reference model plus directed literal checks.
// Mask scenarios run only when SLICE_SEQ_MASK_EN is defined.
module tb_slice_seq_be;
    import pkg_tpu::*;

    logic                 clock = 1'b0;
    logic                 reset;
    logic                 I_Req;
    op_t                  I_Op;
    index_t               I_Last_Idx;
    logic [NUM_SLICE-1:0] mask_in;
    logic                 O_Stall;
    logic                 I_Stall;
    logic                 O_Valid;
    op_t                  O_Op;
    index_t               O_Slice_Idx;

    int errors = 0;
    int checks = 0;
    int n;

    always #5 clock = ~clock;

    slice_seq_be #(.NUM_SLICE(NUM_SLICE)) dut (
        .clock       (clock),
        .reset       (reset),
        .I_Req       (I_Req),
        .I_Op        (I_Op),
        .I_Last_Idx  (I_Last_Idx),
`ifdef SLICE_SEQ_MASK_EN
        .I_Slice_Mask(mask_in),
`endif
        .O_Stall     (O_Stall),
        .I_Stall     (I_Stall),
        .O_Valid     (O_Valid),
        .O_Op        (O_Op),
        .O_Slice_Idx (O_Slice_Idx)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the current slice plus a queue of the slices still owed.
    logic       m_valid = 1'b0;
    logic [7:0] m_op    = 8'h00;
    int         m_idx   = 0;
    int         m_pend[$];

    function automatic logic m_stall();
        return m_valid && !(m_pend.size() == 0 && !I_Stall);
    endfunction

    always @(posedge clock or posedge reset) begin
        logic acc;
        int   lim;
        int   lst[$];
        if (reset) begin
            m_valid = 1'b0; m_op = 8'h00; m_idx = 0; m_pend.delete();
        end else begin
            acc = I_Req && !m_stall();
            if (m_valid && I_Stall) begin
                m_idx = m_idx;
            end else if (m_valid && m_pend.size() > 0) begin
                m_idx = m_pend.pop_front();
            end else if (acc) begin
                lim = (int'(I_Last_Idx) > NUM_SLICE - 1) ? NUM_SLICE - 1 : int'(I_Last_Idx);
                lst.delete();
                for (int j = 0; j <= lim; j++)
                    if (mask_in[j]) lst.push_back(j);
                if (lst.size() == 0) begin
                    m_valid = 1'b0; m_op = 8'h00; m_idx = 0; m_pend.delete();
                end else begin
                    m_valid = 1'b1; m_op = I_Op; m_idx = lst.pop_front(); m_pend = lst;
                end
            end else begin
                m_valid = 1'b0; m_op = 8'h00; m_idx = 0; m_pend.delete();
            end
        end
    end

    always @(negedge clock) begin
        chk("cmp_valid", 32'(O_Valid), 32'(m_valid));
        chk("cmp_op", 32'(O_Op), 32'(m_op));
        chk("cmp_idx", 32'(O_Slice_Idx), 32'(m_idx));
        chk("cmp_stall", 32'(O_Stall), 32'(m_stall()));
    end

    task automatic tick();
        @(posedge clock); #2;
    endtask

    task automatic at_neg();
        @(negedge clock); #1;
    endtask

    task automatic offer(input logic [7:0] op, input index_t last);
        I_Req = 1'b1; I_Op = op; I_Last_Idx = last;
    endtask

    task automatic idle_in();
        I_Req = 1'b0; I_Op = '0; I_Last_Idx = '0;
    endtask

    task automatic count_slices(input int window, output int cnt);
        cnt = 0;
        for (int k = 0; k < window; k++) begin
            at_neg();
            if (O_Valid) cnt++;
        end
    endtask

    initial begin
        reset = 1'b1; I_Stall = 1'b0; mask_in = '1;
        idle_in();
        tick(); tick();
        at_neg();
        chk("rst_valid", 32'(O_Valid), 32'd0);
        chk("rst_op", 32'(O_Op), 32'd0);
        chk("rst_idx", 32'(O_Slice_Idx), 32'd0);
        chk("rst_stall", 32'(O_Stall), 32'd0);
        tick(); reset = 1'b0; tick();

        // Basic expansion, last=3
        offer(8'hA5, 4'd3); tick(); idle_in();
        for (int k = 0; k < 4; k++) begin
            at_neg();
            chk("basic_valid", 32'(O_Valid), 32'd1);
            chk("basic_idx", 32'(O_Slice_Idx), 32'(k));
            chk("basic_op", 32'(O_Op), 32'hA5);
            chk("basic_stall", 32'(O_Stall), (k < 3) ? 32'd1 : 32'd0);
            tick();
        end
        at_neg();
        chk("basic_idle", 32'(O_Valid), 32'd0);
        tick();

        // Backend stall holds index 1 for three cycles
        offer(8'h3C, 4'd3); tick(); idle_in();
        tick();
        I_Stall = 1'b1;
        at_neg(); chk("stall_idx_a", 32'(O_Slice_Idx), 32'd1); chk("stall_ostall", 32'(O_Stall), 32'd1);
        tick();
        at_neg(); chk("stall_idx_b", 32'(O_Slice_Idx), 32'd1); chk("stall_op", 32'(O_Op), 32'h3C);
        tick(); I_Stall = 1'b0;
        at_neg(); chk("stall_idx_c", 32'(O_Slice_Idx), 32'd1);
        tick(); tick();
        at_neg(); chk("stall_idx3", 32'(O_Slice_Idx), 32'd3); chk("stall_v3", 32'(O_Valid), 32'd1);
        tick();

        // Back-to-back; the offer held during stalled slices must be ignored
        offer(8'hA5, 4'd3); tick();
        I_Op = 8'hFF; I_Last_Idx = 4'd0;
        tick(); tick(); tick();
        offer(8'h5A, 4'd1);
        at_neg(); chk("b2b_last_idx", 32'(O_Slice_Idx), 32'd3); chk("b2b_last_stall", 32'(O_Stall), 32'd0);
        tick(); idle_in();
        at_neg(); chk("b2b_valid", 32'(O_Valid), 32'd1); chk("b2b_op", 32'(O_Op), 32'h5A);
        chk("b2b_idx0", 32'(O_Slice_Idx), 32'd0);
        tick();
        at_neg(); chk("b2b_idx1", 32'(O_Slice_Idx), 32'd1);
        tick();
        at_neg(); chk("b2b_idle", 32'(O_Valid), 32'd0);
        tick();

        // I_Stall has no effect in IDLE; accepted op then holds slice 0
        I_Stall = 1'b1; tick(); tick();
        at_neg(); chk("idle_stall", 32'(O_Stall), 32'd0);
        tick();
        offer(8'h11, 4'd1); tick(); idle_in();
        at_neg(); chk("idle_acc_v", 32'(O_Valid), 32'd1); chk("idle_acc_idx", 32'(O_Slice_Idx), 32'd0);
        tick();
        at_neg(); chk("idle_acc_hold", 32'(O_Slice_Idx), 32'd0);
        I_Stall = 1'b0;
        tick(); tick(); tick();

        // Clamp at NUM_SLICE-1 and single-slice op
        offer(8'hC3, 4'd15); tick(); idle_in();
        count_slices(40, n);
        chk("clamp_count", 32'(n), 32'd16);
        tick();
        offer(8'h44, 4'd0); tick(); idle_in();
        count_slices(8, n);
        chk("single_count", 32'(n), 32'd1);
        tick();

        // Asynchronous reset in the middle of an op
        offer(8'h77, 4'd5); tick(); idle_in();
        tick(); tick();
        chk("mid_idx2", 32'(O_Slice_Idx), 32'd2);
        reset = 1'b1; #1;
        chk("mid_rst_valid", 32'(O_Valid), 32'd0);
        chk("mid_rst_op", 32'(O_Op), 32'd0);
        chk("mid_rst_idx", 32'(O_Slice_Idx), 32'd0);
        tick(); reset = 1'b0;
        count_slices(20, n);
        chk("mid_after_count", 32'(n), 32'd0);
        tick();

`ifdef SLICE_SEQ_MASK_EN
        // Mask 0x0025 with last=5 issues 0,2,5
        mask_in = 16'h0025; offer(8'h99, 4'd5); tick(); idle_in();
        at_neg(); chk("mask_idx0", 32'(O_Slice_Idx), 32'd0); chk("mask_st0", 32'(O_Stall), 32'd1);
        tick();
        at_neg(); chk("mask_idx2", 32'(O_Slice_Idx), 32'd2); chk("mask_st2", 32'(O_Stall), 32'd1);
        tick();
        at_neg(); chk("mask_idx5", 32'(O_Slice_Idx), 32'd5); chk("mask_st5", 32'(O_Stall), 32'd0);
        tick();
        at_neg(); chk("mask_idle", 32'(O_Valid), 32'd0);
        tick();
        mask_in = 16'h0000; offer(8'h66, 4'd7); tick(); idle_in();
        at_neg(); chk("mask0_valid", 32'(O_Valid), 32'd0); chk("mask0_stall", 32'(O_Stall), 32'd0);
        tick();
        at_neg(); chk("mask0_valid2", 32'(O_Valid), 32'd0);
        mask_in = '1;
        tick();
`endif

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/slice_seq_be.md
SLICE_SEQ_BE -- requirements
Module: slice_seq_be

Interface
- REQ-001 SHALL have parameter NUM_SLICE, default 16: number of slices; its index width SHALL equal the width of pkg_tpu::index_t.
- REQ-002 SHALL have ports, in this order:
  - clock, input, 1: single clock, rising edge.
  - reset, input, 1: asynchronous reset, active-high.
  - I_Req, input, 1: upstream offers an op.
  - I_Op, input, op_t: offered op.
  - I_Last_Idx, input, index_t: last slice index to issue.
  - O_Stall, output, 1: upstream hold; the offer is ignored while this is high.
  - I_Stall, input, 1: backend stall, the same signal that feeds the pipereg_be stages.
  - O_Valid, output, 1: O_Op and O_Slice_Idx carry a live slice.
  - O_Op, output, op_t: op driven into the backend pipe.
  - O_Slice_Idx, output, index_t: slice index driven into the backend pipe.
- REQ-003 SHALL use one clock; reset is asynchronous and active-high.

Function
- REQ-004 SHALL implement a two-state FSM:
  - IDLE: no op in progress.
  - ISSUE: an op is being expanded into slices.
- REQ-005 Acceptance:
  - An offer is accepted when I_Req=1 and O_Stall=0.
  - On acceptance, the block captures I_Op, captures min(I_Last_Idx, NUM_SLICE-1), and sets the index to 0.
- REQ-006 Latency: an op accepted at edge t SHALL present slice 0 (O_Valid=1) in the cycle after edge t.
- REQ-007 In ISSUE, when I_Stall=1, O_Valid, O_Op, O_Slice_Idx and the internal index SHALL all hold.
- REQ-008 In ISSUE, when I_Stall=0 and index < last, the index SHALL increment by 1 per cycle.
- REQ-009 When I_Stall=0 and index == last:
  - If an offer is accepted in that cycle, the FSM stays in ISSUE and the next slice presented is slice 0 of the new op (back-to-back, no bubble).
  - Otherwise the FSM goes to IDLE.
- REQ-010 O_Stall SHALL be a combinational function of registered state and I_Stall:
  - O_Stall = (state==ISSUE) & ~((index==last) & ~I_Stall).
- REQ-011 Outputs in IDLE:
  - O_Valid=0, O_Op='0 (NOP bubble), O_Slice_Idx='0.
  - I_Stall SHALL have no effect in IDLE.
- REQ-012 I_Last_Idx=0 SHALL issue exactly one slice.
- REQ-013 I_Req asserted while O_Stall=1 SHALL be ignored; the input is not captured.
- REQ-014 O_Valid, O_Op and O_Slice_Idx SHALL be registered outputs.

Reset
- REQ-015 Reset, including assertion in the middle of an op, SHALL asynchronously force IDLE, O_Valid=0, O_Op='0, O_Slice_Idx='0, index=0 and last=0.
- REQ-016 The op in flight at reset SHALL be dropped; no partial slices are issued after reset deasserts.

Configuration
- REQ-017 Macro SLICE_SEQ_MASK_EN:
  - When defined: input I_Slice_Mask [NUM_SLICE-1:0] is added after I_Last_Idx and captured on acceptance.
  - Only slices whose mask bit is 1 and whose index is <= last are issued, in ascending order; the index jumps directly to the next set bit.
  - "index==last" in REQ-009 and REQ-010 becomes "no further enabled slice".
  - An accepted op with no enabled slice produces no output and the FSM remains in IDLE.
- REQ-018 When SLICE_SEQ_MASK_EN is undefined, the port is absent and all slices 0..last are issued.

Structure
- REQ-019 op_t, index_t, NUM_SLICE and the FSM enum slice_seq_state_t SHALL reside in pkg_tpu.
- REQ-020 Under SLICE_SEQ_MASK_EN, a combinational sub-module slice_next_idx SHALL return the next set mask bit above the current index, plus a none-left flag.

Verification
- REQ-021 The bench SHALL cover these scenarios:
  - Basic expansion: op A, I_Last_Idx=3, I_Stall=0 -> O_Slice_Idx 0,1,2,3 on four consecutive cycles starting one cycle after acceptance; O_Stall high for the first three of those cycles; then IDLE.
  - Stall hold: I_Stall=1 for 2 cycles while index=1 -> index 1 is held for 3 cycles total with O_Op unchanged; index 3 is still issued.
  - Back-to-back: op B offered during A's last slice -> B slice 0 follows A slice 3 with no O_Valid gap.
  - Clamp and single slice: I_Last_Idx=NUM_SLICE-1 with a larger raw value -> exactly 16 slices; I_Last_Idx=0 -> exactly 1 slice.
  - Reset mid-op: reset at index 2 -> outputs become 0 in the same cycle and nothing is issued afterwards.
  - Mask (SLICE_SEQ_MASK_EN): mask=16'h0025, last=5 -> slice indices 0,2,5; mask=0 -> no O_Valid and O_Stall stays 0.
